// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, press/release pulses.
// Define BTN_AUTOREPEAT_EN to build the held-button auto-repeat generator.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic is_repeat
);

  localparam int unsigned   CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Every count below relies on a terminal value of at least 1.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept_press_c;
  logic             accept_release_c;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             phase_q, phase_d;
  logic             is_rpt_q, is_rpt_d;
  logic             rpt_hit_c;
`endif

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q <= '0;
      phase_q   <= 1'b0;
      is_rpt_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q <= rpt_cnt_d;
      phase_q   <= phase_d;
      is_rpt_q  <= is_rpt_d;
`endif
    end
  end

  // Next-state and debounce counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = DB_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      DB_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = DB_RELEASE;
          cnt_d   = CNT_ONE;
        end
      end
      DB_RELEASE: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept_press_c   = (state_q == DB_PRESS)   &&  s2_q && (cnt_q == CNT_LAST);
  assign accept_release_c = (state_q == DB_RELEASE) && !s2_q && (cnt_q == CNT_LAST);

`ifdef BTN_AUTOREPEAT_EN
  assign rpt_hit_c = phase_q ? (rpt_cnt_q == RPT_PERIOD_LAST) : (rpt_cnt_q == RPT_DELAY_LAST);
`endif

  // Output and repeat-generator next values.
  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d = rpt_cnt_q;
    phase_d   = phase_q;
    is_rpt_d  = 1'b0;
`endif
    if (accept_press_c) begin
      level_d = 1'b1;
      press_d = 1'b1;
    end
    if (accept_release_c) begin
      level_d   = 1'b0;
      release_d = 1'b1;
    end
`ifdef BTN_AUTOREPEAT_EN
    // Repeat timing only advances on steady HELD cycles; DB_RELEASE freezes it.
    if (accept_press_c || accept_release_c) begin
      rpt_cnt_d = '0;
      phase_d   = 1'b0;
    end else if (state_q == HELD && s2_q) begin
      if (rpt_hit_c) begin
        rpt_cnt_d = '0;
        phase_d   = 1'b1;
        press_d   = 1'b1;
        is_rpt_d  = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RPT_ONE;
      end
    end
`endif
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
`ifdef BTN_AUTOREPEAT_EN
  assign is_repeat     = is_rpt_q;
`else
  assign is_repeat     = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus random button
// activity, checked every cycle against a run-length reference model.
module tb_btn_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic is_repeat;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .is_repeat    (is_repeat)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: synchroniser delay, run of samples disagreeing with the
  // accepted level, and number of steady held cycles since the accepted press.
  bit m_s1, m_s2, m_lvl, m_press, m_rel, m_rep;
  int m_run, m_held;

  int edge_n = 0;
  int press_cnt = 0, rel_cnt = 0;
  int last_init_press = 0, last_rel = 0;
  int rep_offs[$];
  int exp_offs[$];
  int e0, pc, rc;

  task automatic model_edge();
    bit sample;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_rep = 0;
      m_run = 0; m_held = 0;
      return;
    end
    sample  = m_s2;
    m_s2    = m_s1;
    m_s1    = btn_in;
    m_press = 0; m_rel = 0; m_rep = 0;
    if (sample != m_lvl) begin
      m_run++;
      if (m_run == DB) begin
        m_lvl  = sample;
        m_run  = 0;
        m_held = 0;
        if (sample) m_press = 1;
        else        m_rel   = 1;
      end
    end else begin
      if (m_lvl && m_run == 0) begin
        m_held++;
`ifdef BTN_AUTOREPEAT_EN
        if (m_held >= RD && (m_held - RD) % RP == 0) begin
          m_press = 1;
          m_rep   = 1;
        end
`endif
      end
      m_run = 0;
    end
  endtask

  task automatic step(input logic b, input logic r);
    btn_in = b;
    rst    = r;
    @(posedge clk);
    model_edge();
    edge_n++;
    #1;
    checks += 5;
    assert (btn_level === m_lvl) else begin
      errors++;
      $error("FAIL btn_level edge=%0d observed=%0b expected=%0b", edge_n, btn_level, m_lvl);
    end
    assert (press_pulse === m_press) else begin
      errors++;
      $error("FAIL press_pulse edge=%0d observed=%0b expected=%0b", edge_n, press_pulse, m_press);
    end
    assert (release_pulse === m_rel) else begin
      errors++;
      $error("FAIL release_pulse edge=%0d observed=%0b expected=%0b", edge_n, release_pulse, m_rel);
    end
    assert (is_repeat === m_rep) else begin
      errors++;
      $error("FAIL is_repeat edge=%0d observed=%0b expected=%0b", edge_n, is_repeat, m_rep);
    end
    assert (!(press_pulse && release_pulse)) else begin
      errors++;
      $error("FAIL pulse_overlap edge=%0d observed=1 expected=0", edge_n);
    end
    if (press_pulse === 1'b1) begin
      if (is_repeat === 1'b1) rep_offs.push_back(edge_n - last_init_press);
      else begin
        press_cnt++;
        last_init_press = edge_n;
      end
    end
    if (release_pulse === 1'b1) begin
      rel_cnt++;
      last_rel = edge_n;
    end
  endtask

  initial begin
`ifdef BTN_AUTOREPEAT_EN
    exp_offs = '{20, 28, 36, 44, 52};
`endif
    // Reset with the button pressed: everything stays low.
    repeat (3) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0);

    // Clean press: pulse after e5.
    e0 = edge_n + 1;
    pc = press_cnt;
    repeat (40) step(1'b1, 1'b0);
    checks += 2;
    assert (press_cnt === pc + 1) else begin
      errors++;
      $error("FAIL clean_press_count observed=%0d expected=%0d", press_cnt, pc + 1);
    end
    assert (last_init_press - e0 === 5) else begin
      errors++;
      $error("FAIL press_latency observed=%0d expected=5", last_init_press - e0);
    end

    // Clean release: pulse five edges after the drop.
    e0 = edge_n + 1;
    rc = rel_cnt;
    repeat (10) step(1'b0, 1'b0);
    checks += 2;
    assert (rel_cnt === rc + 1) else begin
      errors++;
      $error("FAIL clean_release_count observed=%0d expected=%0d", rel_cnt, rc + 1);
    end
    assert (last_rel - e0 === 5) else begin
      errors++;
      $error("FAIL release_latency observed=%0d expected=5", last_rel - e0);
    end

    // Three-cycle high glitch from idle.
    pc = press_cnt;
    repeat (3) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    checks += 1;
    assert (press_cnt === pc) else begin
      errors++;
      $error("FAIL high_glitch_press observed=%0d expected=%0d", press_cnt, pc);
    end

    // Three-cycle low glitch while held.
    repeat (10) step(1'b1, 1'b0);
    rc = rel_cnt;
    repeat (3) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);
    checks += 2;
    assert (rel_cnt === rc) else begin
      errors++;
      $error("FAIL low_glitch_release observed=%0d expected=%0d", rel_cnt, rc);
    end
    assert (btn_level === 1'b1) else begin
      errors++;
      $error("FAIL low_glitch_level observed=%0b expected=1", btn_level);
    end
    repeat (10) step(1'b0, 1'b0);

    // Long hold: repeat spacing relative to the initial pulse.
    rep_offs.delete();
    repeat (6) step(1'b1, 1'b0);
    repeat (59) step(1'b1, 1'b0);
    checks += 1;
    assert (rep_offs.size() === exp_offs.size()) else begin
      errors++;
      $error("FAIL repeat_count observed=%0d expected=%0d", rep_offs.size(), exp_offs.size());
    end
    for (int i = 0; i < exp_offs.size() && i < rep_offs.size(); i++) begin
      checks++;
      assert (rep_offs[i] === exp_offs[i]) else begin
        errors++;
        $error("FAIL repeat_offset[%0d] observed=%0d expected=%0d", i, rep_offs[i], exp_offs[i]);
      end
    end
    repeat (10) step(1'b0, 1'b0);

    // Reset while held: no release, then a fresh non-repeat press.
    repeat (12) step(1'b1, 1'b0);
    rc = rel_cnt;
    step(1'b1, 1'b1);
    checks += 2;
    assert (btn_level === 1'b0) else begin
      errors++;
      $error("FAIL reset_level observed=%0b expected=0", btn_level);
    end
    assert (rel_cnt === rc) else begin
      errors++;
      $error("FAIL reset_release observed=%0d expected=%0d", rel_cnt, rc);
    end
    e0 = edge_n + 1;
    pc = press_cnt;
    repeat (10) step(1'b1, 1'b0);
    checks += 2;
    assert (press_cnt === pc + 1) else begin
      errors++;
      $error("FAIL post_reset_press observed=%0d expected=%0d", press_cnt, pc + 1);
    end
    assert (last_init_press - e0 === 5) else begin
      errors++;
      $error("FAIL post_reset_latency observed=%0d expected=5", last_init_press - e0);
    end
    repeat (10) step(1'b0, 1'b0);

    // Random bursts with occasional resets.
    for (int n = 0; n < 80; n++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 19) == 0) step(lvl, 1'b1);
      for (int k = 0; k < len; k++) step(lvl, 1'b0);
    end
    repeat (10) step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions one raw push-button input for the board front-end: it synchronises, debounces and converts the button into single-cycle press and release events. With auto-repeat compiled in, a held button also emits periodic repeated press events. One instance sits directly upstream of each scroll/select button consumer (right, left, centre) of the scroll display stage. That stage's `scroll_index` update and `reload` logic consume `press_pulse` directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 100000 — consecutive synchronised samples required to accept a level change; legal range ≥ 2.
- `REPEAT_DELAY`, default 50000000 — held-cycles from initial press pulse to first repeat pulse; ≥ 2; used only with auto-repeat.
- `REPEAT_PERIOD`, default 10000000 — held-cycles between subsequent repeat pulses; ≥ 2; used only with auto-repeat.

Ports:
- `clk` input 1 — system clock; all logic on rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `btn_in` input 1 — raw asynchronous button level, 1 = pressed.
- `btn_level` output 1 — debounced button level.
- `press_pulse` output 1 — one-cycle pulse on accepted press and on each repeat.
- `release_pulse` output 1 — one-cycle pulse on accepted release.
- `is_repeat` output 1 — qualifies `press_pulse`; 1 only when that pulse is a repeat.

## Operation
- 2-FF synchroniser: `btn_in` → `s1` → `s2`; both flops reset to 0. The FSM sees only `s2`.
- Debounce counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits. All outputs are registered.
- FSM states: IDLE, DB_PRESS, HELD, DB_RELEASE.
- **IDLE** (`btn_level`=0):
  - `s2`=1 → DB_PRESS, `cnt`←1.
- **DB_PRESS**:
  - `s2`=0 → IDLE, `cnt`←0, no output.
  - `s2`=1 and `cnt`=DEBOUNCE_CYCLES−1 → HELD. Set `btn_level`←1 and `press_pulse`←1 for one cycle; clear the repeat counter and phase.
  - Otherwise `cnt`++.
- **HELD**:
  - `s2`=0 → DB_RELEASE, `cnt`←1.
  - Otherwise run the repeat logic (if compiled in).
- **DB_RELEASE** (`btn_level` stays 1):
  - `s2`=1 → HELD, `cnt`←0, no pulse.
  - `s2`=0 and `cnt`=DEBOUNCE_CYCLES−1 → IDLE. Set `btn_level`←0 and `release_pulse`←1 for one cycle; clear repeat state.
  - Otherwise `cnt`++.
- Repeat logic (HELD only):
  - The repeat counter increments every HELD cycle. It is frozen, and emits nothing, in DB_RELEASE; a bounce back to HELD resumes it.
  - Phase 0: counter = REPEAT_DELAY−1 → `press_pulse`=1, `is_repeat`=1, counter←0, phase←1.
  - Phase 1: counter = REPEAT_PERIOD−1 → same pulse, counter←0.
- `press_pulse` and `release_pulse` are never high in the same cycle. `is_repeat` is 0 whenever `press_pulse` is 0.

## Timing
- Reset values: `btn_level`=0, `press_pulse`=0, `release_pulse`=0, `is_repeat`=0. The FSM is in IDLE, all counters are 0 and `s1`/`s2` are 0.
- Press latency:
  - With `btn_in` rising before edge e0 and held, `btn_level`↑ and `press_pulse` assert after edge e(DEBOUNCE_CYCLES+1).
  - Release latency is identical.
- Glitch rejection: a level change lasting fewer than DEBOUNCE_CYCLES synchronised samples produces no output change.
- Repeat spacing (measured from the cycle of the initial press pulse):
  - First repeat at +REPEAT_DELAY cycles.
  - Subsequent repeats every REPEAT_PERIOD cycles.
  - Cycles spent in DB_RELEASE extend these intervals.
- Reset mid-operation:
  - Outputs clear on the edge where `rst`=1; no `release_pulse` is generated.
  - A button still held after `rst` deasserts is re-debounced and produces a fresh non-repeat press pulse.
- Counters never wrap: each is cleared at its terminal value or on leaving its state.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - The repeat counter and phase are built.
  - HELD emits repeat pulses as specified, with `is_repeat`=1 on each.
- Not defined:
  - No repeat hardware is built; `is_repeat` is tied to 0.
  - Exactly one `press_pulse` per accepted press; HELD only watches for release.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset: `rst`=1 for 3 cycles with `btn_in`=1 → all outputs 0 throughout.
- Clean press/release:
  - Raise `btn_in` before e0, hold 40 cycles → `press_pulse`=1 for one cycle and `btn_level`↑ after e5 (`is_repeat`=0).
  - Drop `btn_in` → `release_pulse`=1 for one cycle and `btn_level`↓ five edges after the drop's first edge.
- Bounce rejection:
  - 3-cycle high glitch from IDLE → no outputs.
  - 3-cycle low glitch while held → `btn_level` stays 1, no `release_pulse`.
- Auto-repeat (macro defined): hold 60 cycles after the initial pulse → repeat pulses with `is_repeat`=1 at +20, +28, +36, +44, +52. With the macro undefined → no pulses after the initial one.
- Reset mid-hold: assert `rst` in HELD → outputs 0 next edge, no `release_pulse`. Deassert with `btn_in`=1 → new `press_pulse` (`is_repeat`=0) after edge e5 relative to deassert.
